bcd_seg_scanner: RTL and testbench

BCD_SEG_SCANNER -- requirements
Module: bcd_seg_scanner

---
 rtl/bcd_disp_pkg.sv | 33 +++
 rtl/bcd_to_seg.sv | 26 ++
 rtl/bcd_seg_scanner.sv | 115 +++++++++++
 tb/tb_bcd_seg_scanner.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants for the two-digit BCD scanner: active-low segment glyphs,
// position encoding and anode helpers.
package bcd_disp_pkg;

    typedef logic [1:0] pos_t;

    localparam pos_t POS_UNITS = 2'd0;
    localparam pos_t POS_TENS  = 2'd1;
    localparam pos_t POS_DIR   = 2'd2;

    // Active-low, bit 0 = CA ... bit 6 = CG.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_U     = 7'h41;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [7:0] AN_ALL_OFF = 8'hFF;

    function automatic logic [7:0] an_for_pos(input pos_t p);
        return ~(8'd1 << p);
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; 10-15 render as a dash.
module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Three-position multiplexed display: units, tens, direction glyph, with a blank
// cycle before each hold. Define LEADING_ZERO_BLANK_EN to blank a zero tens digit.
module bcd_seg_scanner
    import bcd_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 4
) (
    input  logic       clk_out,
    input  logic       rst_n,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    input  logic       dir,
    input  logic       upd,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam logic [15:0] CNT_LAST = 16'(REFRESH_DIV - 1);

    logic [15:0] cnt_q, cnt_d;
    pos_t        idx_q, idx_d;
    logic [3:0]  cap1_q, cap1_d;
    logic [3:0]  cap0_q, cap0_d;
    logic        capdir_q, capdir_d;
    logic        started_q, started_d;
    logic [7:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q;
    logic [3:0]  bcd_src;
    logic [6:0]  digit_seg;

    assign bcd_src = (idx_d == POS_TENS) ? cap1_d : cap0_d;

    bcd_to_seg u_bcd_to_seg (
        .bcd_i (bcd_src),
        .seg_o (digit_seg)
    );

    always_comb begin
        cap1_d   = upd ? digit1 : cap1_q;
        cap0_d   = upd ? digit0 : cap0_q;
        capdir_d = upd ? dir    : capdir_q;

        started_d = 1'b1;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        // First edge after reset is a plain blank cycle at position 0.
        if (!started_q) begin
            cnt_d = '0;
            idx_d = POS_UNITS;
        end else if (cnt_q >= CNT_LAST) begin
            cnt_d = '0;
            case (idx_q)
                POS_UNITS: idx_d = POS_TENS;
                POS_TENS:  idx_d = POS_DIR;
                default:   idx_d = POS_UNITS;
            endcase
        end else begin
            cnt_d = cnt_q + 16'd1;
            idx_d = (idx_q == 2'd3) ? POS_UNITS : idx_q;
        end
    end

    // Glyph and anode are latched at hold start so a capture never disturbs a hold.
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        if (cnt_d == 16'd0) begin
            an_d  = AN_ALL_OFF;
            seg_d = SEG_BLANK;
        end else if (cnt_d == 16'd1) begin
            an_d = an_for_pos(idx_d);
            case (idx_d)
                POS_UNITS, POS_TENS: seg_d = digit_seg;
                default:             seg_d = capdir_d ? SEG_U : SEG_D;
            endcase
`ifdef LEADING_ZERO_BLANK_EN
            if (idx_d == POS_TENS && cap1_d == 4'd0) begin
                an_d  = AN_ALL_OFF;
                seg_d = SEG_BLANK;
            end
`endif
        end
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= POS_UNITS;
            cap1_q    <= 4'd0;
            cap0_q    <= 4'd0;
            capdir_q  <= 1'b1;
            started_q <= 1'b0;
            an_q      <= AN_ALL_OFF;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            cap1_q    <= cap1_d;
            cap0_q    <= cap0_d;
            capdir_q  <= capdir_d;
            started_q <= started_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= 1'b1;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Scoreboard bench for bcd_seg_scanner: stimulus pushes expected per-position
// anode/segment pairs, a monitor checks every cycle of every frame.
module tb_bcd_seg_scanner;

    localparam int DIV   = 4;
    localparam int FRAME = 3 * DIV;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
    } exp_t;

    typedef struct {
        logic [3:0] d1;
        logic [3:0] d0;
        logic       dir;
        int         kmod;
        logic [6:0] e0;
        logic [6:0] e1;
        logic [6:0] e2;
    } vec_t;

    logic       clk_out;
    logic       rst_n;
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic       dir;
    logic       upd;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int   checks;
    int   failures;
    int   k;
    int   fs;
    logic mon_en;
    exp_t exp_q[$];
    exp_t cur;
    vec_t vecs[7];

    bcd_seg_scanner #(
        .REFRESH_DIV (DIV)
    ) dut (
        .clk_out (clk_out),
        .rst_n   (rst_n),
        .digit1  (digit1),
        .digit0  (digit0),
        .dir     (dir),
        .upd     (upd),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    initial clk_out = 1'b0;
    always #5 clk_out = ~clk_out;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [6:0] e0, input logic [6:0] e1,
                              input logic [3:0] d1, input logic [6:0] e2);
        exp_q.push_back('{an: 8'hFE, seg: e0});
`ifdef LEADING_ZERO_BLANK_EN
        if (d1 == 4'd0) exp_q.push_back('{an: 8'hFF, seg: 7'h7F});
        else            exp_q.push_back('{an: 8'hFD, seg: e1});
`else
        if (d1 == 4'd15) exp_q.push_back('{an: 8'hFD, seg: 7'h3F});
        else             exp_q.push_back('{an: 8'hFD, seg: e1});
`endif
        exp_q.push_back('{an: 8'hFB, seg: e2});
    endtask

    task automatic wait_abs(input int target);
        int n;
        n = 0;
        do begin
            @(posedge clk_out);
            #1;
            n++;
        end while (k != target && n < 400);
        if (k != target) begin
            checks++;
            failures++;
            $display("FAIL wait_timeout actual=%0d required=%0d", k, target);
        end
    endtask

    task automatic do_capture(input vec_t v);
        wait_abs(fs - FRAME + v.kmod);
        digit1 = v.d1;
        digit0 = v.d0;
        dir    = v.dir;
        upd    = 1'b1;
        push_frame(v.e0, v.e1, v.d1, v.e2);
        fs += FRAME;
        @(posedge clk_out);
        #1;
        upd = 1'b0;
    endtask

    // Monitor: k counts edges since reset release; phase 0 must be blank, the
    // rest of each hold must match the entry popped at phase 1.
    initial begin : monitor
        int phase;
        cur = '{an: 8'hFF, seg: 7'h7F};
        forever begin
            @(negedge clk_out);
            if (!rst_n) begin
                k = 0;
            end else begin
                if (mon_en) begin
                    phase = k % DIV;
                    if (phase == 0) begin
                        check($sformatf("blank_an k=%0d", k), 16'(an), 16'h00FF);
                        check($sformatf("blank_seg k=%0d", k), 16'(seg), 16'h007F);
                    end else begin
                        if (phase == 1) begin
                            if (exp_q.size() == 0) begin
                                checks++;
                                failures++;
                                $display("FAIL scoreboard_empty actual=0 required=1 k=%0d", k);
                            end else begin
                                cur = exp_q.pop_front();
                            end
                        end
                        check($sformatf("hold_an k=%0d", k), 16'(an), 16'(cur.an));
                        check($sformatf("hold_seg k=%0d", k), 16'(seg), 16'(cur.seg));
                        check($sformatf("dp k=%0d", k), 16'(dp), 16'h0001);
                    end
                end
                k++;
            end
        end
    end

    initial begin : stim
        checks   = 0;
        failures = 0;
        k        = 0;
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        digit1   = 4'd0;
        digit0   = 4'd0;
        dir      = 1'b0;
        upd      = 1'b0;

        vecs[0] = '{4'd4, 4'd7,  1'b0, 9,  7'h78, 7'h19, 7'h21};
        vecs[1] = '{4'd4, 4'hC,  1'b0, 9,  7'h3F, 7'h19, 7'h21};
        vecs[2] = '{4'd9, 4'd8,  1'b1, 9,  7'h00, 7'h10, 7'h41};
        vecs[3] = '{4'd9, 4'd9,  1'b1, 9,  7'h10, 7'h10, 7'h41};
        vecs[4] = '{4'd0, 4'd0,  1'b1, 11, 7'h40, 7'h40, 7'h41};
        vecs[5] = '{4'd1, 4'd3,  1'b0, 11, 7'h30, 7'h79, 7'h21};
        vecs[6] = '{4'd0, 4'd5,  1'b1, 9,  7'h12, 7'h40, 7'h41};

        repeat (3) @(negedge clk_out);
        check("reset_an", 16'(an), 16'h00FF);
        check("reset_seg", 16'(seg), 16'h007F);
        check("reset_dp", 16'(dp), 16'h0001);

        // Reset state: cap1=0, cap0=0, capdir=1.
        push_frame(7'h40, 7'h40, 4'd0, 7'h41);
        fs = FRAME;
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        foreach (vecs[i]) do_capture(vecs[i]);

        wait_abs(fs);
        check("queue_drained", 16'(exp_q.size()), 16'h0000);
        mon_en = 1'b0;

        // Asynchronous reset in the middle of the direction-glyph hold.
        wait_abs(fs + 10);
        check("pre_reset_an", 16'(an), 16'h00FB);
        check("pre_reset_seg", 16'(seg), 16'h0041);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_an", 16'(an), 16'h00FF);
        check("async_reset_seg", 16'(seg), 16'h007F);
        repeat (3) @(negedge clk_out);
        check("held_reset_an", 16'(an), 16'h00FF);

        push_frame(7'h40, 7'h40, 4'd0, 7'h41);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        wait_abs(FRAME);
        check("queue_drained_2", 16'(exp_q.size()), 16'h0000);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
